instr_sequencer: RTL and testbench

Issuing side of the start/valid instruction handshake. Holds a small program of DSP instructions and presents them one at a time to the DSP controller. For each instruction it raises start with a stable instruction word, waits for valid, drops start, then waits for valid to clear before issuing the next one. The host writes the program buffer, pulses run and watches busy/done.

---
 rtl/instr_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues a small buffered DSP program over start/valid.
// Ports: load_* write the program buffer while idle; run_i/prog_len_i
// launch a program; start_o/instruction_o/valid_i form the controller
// handshake; busy_o/done_o/err_o/pc_o report status.
// Optional watchdog: define SEQ_TIMEOUT_EN (otherwise err_o is tied to 0).
module instr_sequencer #(
  parameter int unsigned I_WIDTH        = 32,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned PC_WIDTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_we_i,
  input  logic [PC_WIDTH-1:0] load_addr_i,
  input  logic [I_WIDTH-1:0]  load_data_i,
  input  logic                run_i,
  input  logic [PC_WIDTH:0]   prog_len_i,
  output logic                start_o,
  output logic [I_WIDTH-1:0]  instruction_o,
  input  logic                valid_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [PC_WIDTH-1:0] pc_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    RELEASE
  } state_t;

  localparam logic [PC_WIDTH:0] DEPTH_L = (PC_WIDTH+1)'(DEPTH);

  if (TIMEOUT_CYCLES < 1 || DEPTH > (1 << PC_WIDTH)) begin : g_param_check
    $error("instr_sequencer: bad TIMEOUT_CYCLES or DEPTH/PC_WIDTH");
  end

  state_t state, state_n;

  logic [I_WIDTH-1:0]  mem [DEPTH];
  logic [PC_WIDTH-1:0] pc, pc_n, pc_out_n;
  logic [PC_WIDTH:0]   len, len_n, len_clamp, last;
  logic [I_WIDTH-1:0]  instr_n;
  logic                start_n, done_n;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd, wd_n;
  logic            wd_hit;
  logic            err_q, err_n;

  assign wd_hit = (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign err_o  = err_q;
`else
  assign err_o  = 1'b0;
`endif

  assign busy_o    = (state != IDLE);
  assign len_clamp = (prog_len_i > DEPTH_L) ? DEPTH_L : prog_len_i;
  assign last      = len - 1'b1;

  // Program buffer has no reset; writes are only honoured while idle.
  always_ff @(posedge clk_i) begin
    if (load_we_i && state == IDLE)
      mem[load_addr_i] <= load_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      pc            <= '0;
      len           <= '0;
      pc_o          <= '0;
      start_o       <= 1'b0;
      instruction_o <= '0;
      done_o        <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd            <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      len           <= len_n;
      pc_o          <= pc_out_n;
      start_o       <= start_n;
      instruction_o <= instr_n;
      done_o        <= done_n;
`ifdef SEQ_TIMEOUT_EN
      wd            <= wd_n;
      err_q         <= err_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    len_n    = len;
    pc_out_n = pc_o;
    start_n  = start_o;
    instr_n  = instruction_o;
    done_n   = done_o;
`ifdef SEQ_TIMEOUT_EN
    wd_n     = wd;
    err_n    = err_q;
`endif
    unique case (state)
      IDLE: begin
        if (run_i) begin
`ifdef SEQ_TIMEOUT_EN
          err_n = 1'b0;
`endif
          if (prog_len_i == '0) begin
            done_n = 1'b1;
          end else begin
            len_n   = len_clamp;
            pc_n    = '0;
            done_n  = 1'b0;
            state_n = FETCH;
          end
        end
      end
      FETCH: begin
        // Word and start land on the same edge; valid_i is ignored here.
        instr_n  = mem[pc];
        start_n  = 1'b1;
        pc_out_n = pc;
        state_n  = ISSUE;
`ifdef SEQ_TIMEOUT_EN
        wd_n     = '0;
`endif
      end
      ISSUE: begin
        if (valid_i) begin
          start_n = 1'b0;
          state_n = RELEASE;
`ifdef SEQ_TIMEOUT_EN
          wd_n    = '0;
`endif
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_hit) begin
          start_n = 1'b0;
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          wd_n = wd + 1'b1;
        end
`endif
      end
      RELEASE: begin
        // Re-issue only once the controller has cleared valid.
        if (!valid_i) begin
          if ({1'b0, pc} == last) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            pc_n    = pc + 1'b1;
            state_n = FETCH;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_hit) begin
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          wd_n = wd + 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized bench for instr_sequencer with a
// reactive controller model and a program-level reference model.
module tb_instr_sequencer;

  localparam int IW = 32;
  localparam int D  = 16;
  localparam int PW = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_we;
  logic [PW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          run;
  logic [PW:0]   prog_len;
  logic          start;
  logic [IW-1:0] instr;
  logic          valid;
  logic          busy;
  logic          done;
  logic          err;
  logic [PW-1:0] pc;

  instr_sequencer #(
    .I_WIDTH(IW),
    .DEPTH(D),
    .PC_WIDTH(PW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .load_we_i(load_we),
    .load_addr_i(load_addr),
    .load_data_i(load_data),
    .run_i(run),
    .prog_len_i(prog_len),
    .start_o(start),
    .instruction_o(instr),
    .valid_i(valid),
    .busy_o(busy),
    .done_o(done),
    .err_o(err),
    .pc_o(pc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic [IW-1:0] model_mem [D];

  // Controller model: raise valid ctl_lat cycles after start,
  // drop it ctl_hold cycles after start falls.
  bit ctl_en   = 1'b1;
  int ctl_lat  = 11;
  int ctl_hold = 0;
  int c_cnt    = 0;
  int h_cnt    = 0;

  always @(negedge clk) begin
    if (!ctl_en || !rst_n) begin
      valid = 1'b0;
      c_cnt = 0;
      h_cnt = 0;
    end else if (start && !valid) begin
      c_cnt++;
      if (c_cnt >= ctl_lat) begin
        valid = 1'b1;
        c_cnt = 0;
      end
    end else if (valid && !start) begin
      if (h_cnt >= ctl_hold) begin
        valid = 1'b0;
        h_cnt = 0;
      end else begin
        h_cnt++;
      end
    end
  end

  // Handshake monitor, sampled 1 time unit after each rising edge.
  logic [IW-1:0] got_q [$];
  logic          prev_start = 1'b0;
  logic [IW-1:0] prev_instr = '0;
  bit            first      = 1'b1;
  int rises = 0, bad_gap = 0, bad_stable = 0;
  int bad_overlap = 0, bad_lead = 0;
  int low_run = 0, lead = 0, hi_run = 0, last_hi = 0;

  always @(posedge clk) begin
    #1;
    if (start && !prev_start) begin
      rises++;
      got_q.push_back(instr);
      if (valid) bad_overlap++;
      if (!first) begin
        if (low_run < 2) bad_gap++;
        if (lead != 1) bad_lead++;
      end
      first  = 1'b0;
      hi_run = 0;
    end
    if (start && prev_start && instr !== prev_instr) bad_stable++;
    if (start) begin
      hi_run++;
      low_run = 0;
    end else begin
      low_run++;
    end
    if (!start && prev_start) last_hi = hi_run;
    if (valid) lead = 0;
    else lead++;
    if (!busy) first = 1'b1;
    prev_start = start;
    prev_instr = instr;
  end

  function automatic int bad_sum();
    return bad_gap + bad_stable + bad_overlap + bad_lead;
  endfunction

  function automatic int clamp_len(input int len);
    return (len > D) ? D : len;
  endfunction

  task automatic write_word(input logic [PW-1:0] a,
                            input logic [IW-1:0] d);
    @(negedge clk);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_we      = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic run_and_wait(input int len, input int budget,
                              output bit ok);
    @(negedge clk);
    run      = 1'b1;
    prog_len = (PW+1)'(len);
    @(negedge clk);
    run = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int r0;
    rst_n     = 1'b0;
    run       = 1'b1;
    prog_len  = 5'd3;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({start, busy, done, err} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000",
               {start, busy, done, err});
    else n_pass++;
    n_chk++;
    if (pc !== '0 || instr !== '0)
      $display("FAIL reset_pc_instr got %0h/%0h want 0/0", pc, instr);
    else n_pass++;
    r0  = rises;
    run = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || rises != r0)
      $display("FAIL reset_no_issue got busy=%b rises=%0d want 0/0",
               busy, rises - r0);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int r0 = rises;
    @(negedge clk);
    run      = 1'b1;
    prog_len = '0;
    @(negedge clk);
    run = 1'b0;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_len_done got done=%b busy=%b want 1/0",
               done, busy);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++;
    if (rises != r0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL zero_len_quiet got rises=%0d busy=%b err=%b want 0/0/0",
               rises - r0, busy, err);
    else n_pass++;
  endtask

  task automatic test_directed();
    int r0 = rises;
    int q0 = got_q.size();
    int b0 = bad_sum();
    bit ok;
    write_word(4'd0, 32'hA5A5_0001);
    write_word(4'd1, 32'h0000_1234);
    write_word(4'd2, 32'hFFFF_0000);
    ctl_lat  = 11;
    ctl_hold = 0;
    run_and_wait(3, 200, ok);
    n_chk++;
    if (!ok) $display("FAIL directed_timeout got busy=1 want done");
    else n_pass++;
    n_chk++;
    if (rises - r0 != 3)
      $display("FAIL directed_count got %0d want 3", rises - r0);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (got_q.size() <= q0 + i)
        $display("FAIL directed_word%0d got none want %h", i,
                 model_mem[i]);
      else if (got_q[q0+i] !== model_mem[i])
        $display("FAIL directed_word%0d got %h want %h", i,
                 got_q[q0+i], model_mem[i]);
      else n_pass++;
    end
    n_chk++;
    if (done !== 1'b1 || pc !== 4'd2 || err !== 1'b0)
      $display("FAIL directed_status got done=%b pc=%0d err=%b want 1/2/0",
               done, pc, err);
    else n_pass++;
    n_chk++;
    if (bad_sum() != b0)
      $display("FAIL directed_handshake got %0d violations want 0",
               bad_sum() - b0);
    else n_pass++;
  endtask

  task automatic test_valid_hold();
    int r0 = rises;
    int q0 = got_q.size();
    int b0 = bad_sum();
    bit ok;
    for (int a = 0; a < 4; a++) write_word(PW'(a), $urandom());
    ctl_lat  = 3;
    ctl_hold = 5;
    run_and_wait(4, 300, ok);
    ctl_hold = 0;
    n_chk++;
    if (!ok || rises - r0 != 4)
      $display("FAIL hold_count got ok=%b rises=%0d want 1/4",
               ok, rises - r0);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (got_q.size() <= q0 + i || got_q[q0+i] !== model_mem[i])
        $display("FAIL hold_word%0d got %h want %h", i,
                 (got_q.size() > q0 + i) ? got_q[q0+i] : 'x,
                 model_mem[i]);
      else n_pass++;
    end
    n_chk++;
    if (bad_sum() != b0)
      $display("FAIL hold_handshake got %0d violations want 0",
               bad_sum() - b0);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int r0 = rises;
    int q0 = got_q.size();
    bit ok;
    ctl_lat = 6;
    @(negedge clk);
    run      = 1'b1;
    prog_len = 5'd4;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    load_we   = 1'b1;
    load_addr = 4'd1;
    load_data = ~model_mem[1];
    run       = 1'b1;
    prog_len  = 5'd1;
    @(negedge clk);
    load_we = 1'b0;
    run     = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (!ok || rises - r0 != 4 || pc !== 4'd3)
      $display("FAIL busy_ignore_run got ok=%b rises=%0d pc=%0d want 1/4/3",
               ok, rises - r0, pc);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (got_q.size() <= q0 + i || got_q[q0+i] !== model_mem[i])
        $display("FAIL busy_ignore_word%0d got %h want %h", i,
                 (got_q.size() > q0 + i) ? got_q[q0+i] : 'x,
                 model_mem[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len = $urandom_range(0, 20);
      int n   = clamp_len(len);
      int r0, q0, b0;
      logic [PW-1:0] pc0;
      bit ok;
      for (int a = 0; a < D; a++) write_word(PW'(a), $urandom());
      ctl_lat  = $urandom_range(1, 6);
      ctl_hold = $urandom_range(0, 4);
      r0  = rises;
      q0  = got_q.size();
      b0  = bad_sum();
      pc0 = pc;
      run_and_wait(len, 1000, ok);
      n_chk++;
      if (!ok || rises - r0 != n)
        $display("FAIL rand%0d_count got ok=%b rises=%0d want 1/%0d",
                 it, ok, rises - r0, n);
      else n_pass++;
      for (int i = 0; i < n; i++) begin
        n_chk++;
        if (got_q.size() <= q0 + i || got_q[q0+i] !== model_mem[i])
          $display("FAIL rand%0d_word%0d got %h want %h", it, i,
                   (got_q.size() > q0 + i) ? got_q[q0+i] : 'x,
                   model_mem[i]);
        else n_pass++;
      end
      n_chk++;
      if (done !== 1'b1 || err !== 1'b0 ||
          pc !== ((n > 0) ? PW'(n - 1) : pc0))
        $display("FAIL rand%0d_status got done=%b err=%b pc=%0d want 1/0/%0d",
                 it, done, err, pc, (n > 0) ? n - 1 : int'(pc0));
      else n_pass++;
      n_chk++;
      if (bad_sum() != b0)
        $display("FAIL rand%0d_handshake got %0d violations want 0",
                 it, bad_sum() - b0);
      else n_pass++;
    end
    ctl_hold = 0;
  endtask

  task automatic test_reset_mid();
    int r0 = rises;
    bit seen = 1'b0;
    ctl_lat = 11;
    @(negedge clk);
    run      = 1'b1;
    prog_len = 5'd3;
    @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (!seen || start !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid_async got seen=%b start=%b busy=%b want 1/0/0",
               seen, start, busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_chk++;
    if (rises - r0 != 1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_mid_quiet got rises=%0d busy=%b done=%b want 1/0/0",
               rises - r0, busy, done);
    else n_pass++;
  endtask

  task automatic test_stall();
    int r0 = rises;
`ifdef SEQ_TIMEOUT_EN
    bit ok;
    ctl_en = 1'b0;
    run_and_wait(3, 300, ok);
    ctl_en = 1'b1;
    n_chk++;
    if (!ok || last_hi != TO || rises - r0 != 1)
      $display("FAIL timeout_issue got ok=%b hi=%0d rises=%0d want 1/%0d/1",
               ok, last_hi, rises - r0, TO);
    else n_pass++;
    n_chk++;
    if (err !== 1'b1 || done !== 1'b1 || pc !== '0)
      $display("FAIL timeout_flags got err=%b done=%b pc=%0d want 1/1/0",
               err, done, pc);
    else n_pass++;
    r0       = rises;
    ctl_lat  = 2;
    ctl_hold = 1000;
    run_and_wait(2, 300, ok);
    ctl_hold = 0;
    n_chk++;
    if (!ok || err !== 1'b1 || done !== 1'b1 || pc !== '0 ||
        rises - r0 != 1)
      $display("FAIL timeout_release got ok=%b err=%b done=%b pc=%0d rises=%0d want 1/1/1/0/1",
               ok, err, done, pc, rises - r0);
    else n_pass++;
    repeat (3) @(negedge clk);
    run_and_wait(1, 100, ok);
    n_chk++;
    if (!ok || err !== 1'b0 || done !== 1'b1)
      $display("FAIL timeout_clear got ok=%b err=%b done=%b want 1/0/1",
               ok, err, done);
    else n_pass++;
`else
    ctl_en = 1'b0;
    @(negedge clk);
    run      = 1'b1;
    prog_len = 5'd3;
    @(negedge clk);
    run = 1'b0;
    repeat (150) @(negedge clk);
    n_chk++;
    if (start !== 1'b1 || busy !== 1'b1 || err !== 1'b0 ||
        rises - r0 != 1)
      $display("FAIL stall_wait got start=%b busy=%b err=%b rises=%0d want 1/1/0/1",
               start, busy, err, rises - r0);
    else n_pass++;
    rst_n  = 1'b0;
    ctl_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || start !== 1'b0)
      $display("FAIL stall_recover got busy=%b start=%b want 0/0",
               busy, start);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_directed();
    test_valid_hold();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    test_stall();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
